// File: rtl/mem_init_gen.sv
// mem_init_gen: sweeps a memory with identity/constant/descending fills or
// read-back verifies an identity fill. Ports: start/mode/fill_value/q in; busy,
// finish, address, data, wen, memory_sel, verify_err, err_addr, err_count out.
module mem_init_gen #(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 8,
  parameter int          DEPTH    = 256,
  parameter int          READ_LAT = 1,
  parameter logic [1:0]  MEM_SEL  = 2'b01,
  parameter int          ERRCNT_W = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   fill_value,
  input  logic [DATA_W-1:0]   q,
  output logic                busy,
  output logic                finish,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   data,
  output logic                wen,
  output logic [1:0]          memory_sel,
  output logic                verify_err,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int CW = ADDR_W + 1;
  localparam int WW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [CW-1:0]     LAST   = CW'(DEPTH - 1);
  localparam logic [CW-1:0]     DLAST  = CW'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DRAIN, DONE
  } state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   fill_q;
  logic [READ_LAT-1:0] dl_vld;
  logic [ADDR_W-1:0]   dl_adr [READ_LAT];
  logic                go;
  logic                miss;

  function automatic logic [DATA_W-1:0] to_data(
    input logic [ADDR_W-1:0] a
  );
    logic [WW-1:0] w;
    w = WW'(a);
    return w[DATA_W-1:0];
  endfunction

  assign go   = (state == IDLE) && start;
  assign miss = dl_vld[READ_LAT-1] &&
                (q != to_data(dl_adr[READ_LAT-1]));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (mode == 2'b11) ? READ : WRITE;
          cnt_nx   = '0;
        end
      end
      WRITE: begin
        if (cnt == LAST) state_nx = DONE;
        else             cnt_nx   = cnt + CW'(1);
      end
      READ: begin
        if (cnt == LAST) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt == DLAST) state_nx = DONE;
        else              cnt_nx   = cnt + CW'(1);
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    finish     = (state == DONE);
    wen        = (state == WRITE);
    memory_sel = busy ? MEM_SEL : 2'b00;
    address    = '0;
    data       = '0;
    unique case (state)
      WRITE: begin
        address = cnt[ADDR_W-1:0];
        unique case (mode_q)
          2'b00:   data = to_data(address);
          2'b01:   data = fill_q;
          2'b10:   data = to_data(LAST_A - address);
          default: data = '0;
        endcase
      end
      READ:    address = cnt[ADDR_W-1:0];
      DRAIN:   address = LAST_A;
      default: address = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= '0;
      fill_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (go) begin
        mode_q <= mode;
        fill_q <= fill_value;
      end
    end
  end

  // Read-address delay line aligning each issued address with its q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld <= '0;
      for (int i = 0; i < READ_LAT; i++) dl_adr[i] <= '0;
    end else begin
      dl_vld[0] <= (state == READ);
      dl_adr[0] <= address;
      for (int i = 1; i < READ_LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_adr[i] <= dl_adr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verify_err <= 1'b0;
      err_addr   <= '0;
      err_count  <= '0;
    end else if (go) begin
      verify_err <= 1'b0;
      err_addr   <= '0;
      err_count  <= '0;
    end else if (miss) begin
      verify_err <= 1'b1;
      if (!verify_err) err_addr <= dl_adr[READ_LAT-1];
      if (err_count != '1) err_count <= err_count + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_init_gen.sv
// tb_mem_init_gen: directed bench for mem_init_gen, a 256-deep READ_LAT=2
// instance backed by a RAM model plus a 16-deep instance for short sweeps.
module tb_mem_init_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start16;
  logic [1:0] mode, mode16;
  logic [7:0] fill_value, fill16;
  logic [7:0] q, q16;
  logic       busy, finish, wen, verify_err;
  logic [7:0] address, data, err_addr;
  logic [1:0] memory_sel;
  logic [8:0] err_count;
  logic       busy16, finish16, wen16, verify_err16;
  logic [7:0] address16, data16, err_addr16;
  logic [1:0] memory_sel16;
  logic [8:0] err_count16;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  logic [7:0] r1;

  int         fin_k, nwen, nbl, ms_bad;
  logic       busy_after, ve_f;
  logic [7:0] ea_f;
  logic [8:0] ec_f;
  logic [7:0] a_log [512];
  logic [7:0] d_log [512];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r1 <= mem[address];
    q  <= r1;
  end

  mem_init_gen #(.READ_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .fill_value(fill_value), .q(q), .busy(busy), .finish(finish),
    .address(address), .data(data), .wen(wen),
    .memory_sel(memory_sel), .verify_err(verify_err),
    .err_addr(err_addr), .err_count(err_count)
  );

  mem_init_gen #(.DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16),
    .fill_value(fill16), .q(q16), .busy(busy16), .finish(finish16),
    .address(address16), .data(data16), .wen(wen16),
    .memory_sel(memory_sel16), .verify_err(verify_err16),
    .err_addr(err_addr16), .err_count(err_count16)
  );

  task automatic run_main(input logic [1:0] m, input logic [7:0] fv);
    @(posedge clk); #1;
    mode = m; fill_value = fv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m;
    fin_k = -1; nwen = 0; nbl = 0; ms_bad = 0;
    for (int k = 0; k < 400; k++) begin
      if (!busy) nbl++;
      if (memory_sel !== 2'b01) ms_bad++;
      if (wen && nwen < 512) begin
        a_log[nwen] = address;
        d_log[nwen] = data;
        nwen++;
      end
      if (k == 100) fill_value = ~fv;
      if (finish) begin
        fin_k = k;
        ve_f = verify_err; ea_f = err_addr; ec_f = err_count;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic run16(input logic [1:0] m);
    @(posedge clk); #1;
    mode16 = m; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    fin_k = -1; nwen = 0;
    for (int k = 0; k < 60; k++) begin
      if (wen16 && nwen < 512) begin
        a_log[nwen] = address16;
        d_log[nwen] = data16;
        nwen++;
      end
      if (finish16) begin
        fin_k = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({busy, finish, address, data, wen, memory_sel,
         verify_err, err_addr, err_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b addr=%h data=%h wen=%b",
               busy, address, data, wen);
    end
    tests++;
    if ({busy16, finish16, wen16, address16, memory_sel16} !== '0) begin
      fails++;
      $display("FAIL reset_outputs16: got busy=%b addr=%h", busy16, address16);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    int bad;
    run_main(2'b00, 8'h00);
    tests++;
    if (fin_k !== 256) begin
      fails++;
      $display("FAIL identity_latency: got %0d want 256", fin_k);
    end
    tests++;
    if (nwen !== 256) begin
      fails++;
      $display("FAIL identity_wen_count: got %0d want 256", nwen);
    end
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (a_log[i] !== 8'(i) || d_log[i] !== 8'(i)) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL identity_data: got %0d bad writes want 0", bad);
    end
    tests++;
    if (nbl !== 0 || ms_bad !== 0) begin
      fails++;
      $display("FAIL identity_busy_sel: got busy_low=%0d sel_bad=%0d want 0",
               nbl, ms_bad);
    end
    tests++;
    if (busy_after !== 1'b0) begin
      fails++;
      $display("FAIL identity_busy_drop: got %b want 0", busy_after);
    end
  endtask

  task automatic test_constant();
    int bad;
    run_main(2'b01, 8'hA5);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (a_log[i] !== 8'(i) || d_log[i] !== 8'hA5) bad++;
    tests++;
    if (nwen !== 256 || bad !== 0) begin
      fails++;
      $display("FAIL constant_data: got nwen=%0d bad=%0d want 256/0",
               nwen, bad);
    end
    tests++;
    if (fin_k !== 256) begin
      fails++;
      $display("FAIL constant_latency: got %0d want 256", fin_k);
    end
  endtask

  task automatic test_descending();
    int bad;
    run_main(2'b10, 8'h00);
    tests++;
    if (d_log[0] !== 8'hFF || d_log[255] !== 8'h00) begin
      fails++;
      $display("FAIL desc_ends: got %h/%h want ff/00", d_log[0], d_log[255]);
    end
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (a_log[i] !== 8'(i) || d_log[i] !== 8'(255 - i)) bad++;
    tests++;
    if (nwen !== 256 || bad !== 0) begin
      fails++;
      $display("FAIL desc_data: got nwen=%0d bad=%0d want 256/0", nwen, bad);
    end
  endtask

  task automatic test_descending16();
    int bad;
    run16(2'b10);
    tests++;
    if (fin_k !== 16) begin
      fails++;
      $display("FAIL desc16_latency: got %0d want 16", fin_k);
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (a_log[i] !== 8'(i) || d_log[i] !== 8'(15 - i)) bad++;
    tests++;
    if (nwen !== 16 || bad !== 0) begin
      fails++;
      $display("FAIL desc16_data: got nwen=%0d bad=%0d want 16/0", nwen, bad);
    end
  endtask

  task automatic test_verify();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h3C] = 8'h00;
    mem[8'h80] = 8'h7F;
    run_main(2'b11, 8'h00);
    tests++;
    if (fin_k !== 258) begin
      fails++;
      $display("FAIL verify_latency: got %0d want 258", fin_k);
    end
    tests++;
    if (nwen !== 0) begin
      fails++;
      $display("FAIL verify_no_write: got %0d want 0", nwen);
    end
    tests++;
    if (ve_f !== 1'b1 || ea_f !== 8'h3C || ec_f !== 9'd2) begin
      fails++;
      $display("FAIL verify_errors: got err=%b addr=%h cnt=%0d want 1/3c/2",
               ve_f, ea_f, ec_f);
    end
    mem[8'h3C] = 8'h3C;
    mem[8'h80] = 8'h80;
    run_main(2'b11, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (ve_f !== 1'b0 || ea_f !== 8'h00 || ec_f !== 9'd0 ||
        verify_err !== 1'b0 || err_count !== 9'd0) begin
      fails++;
      $display("FAIL verify_clean: got err=%b addr=%h cnt=%0d want 0/00/0",
               ve_f, ea_f, ec_f);
    end
    mem[8'h10] = 8'h00;
    run_main(2'b11, 8'h00);
    mem[8'h10] = 8'h10;
    run_main(2'b00, 8'h00);
    tests++;
    if (ve_f !== 1'b0 || ea_f !== 8'h00 || ec_f !== 9'd0) begin
      fails++;
      $display("FAIL write_start_clears: got err=%b addr=%h cnt=%0d want 0",
               ve_f, ea_f, ec_f);
    end
  endtask

  task automatic test_start_held();
    int nfin, nrise, nw;
    logic prev;
    nfin = 0; nrise = 0; nw = 0;
    prev = busy16;
    @(posedge clk); #1;
    start16 = 1'b1; mode16 = 2'b00;
    for (int k = 0; k < 140; k++) begin
      @(posedge clk); #1;
      if (k == 99) start16 = 1'b0;
      if (finish16) nfin++;
      if (wen16) nw++;
      if (busy16 && !prev) nrise++;
      prev = busy16;
    end
    tests++;
    if (nfin !== 6 || nrise !== 6) begin
      fails++;
      $display("FAIL start_held: got fin=%0d acc=%0d want 6/6", nfin, nrise);
    end
    tests++;
    if (nw !== 96) begin
      fails++;
      $display("FAIL start_held_wen: got %0d want 96", nw);
    end
  endtask

  task automatic test_ignored_pulses();
    int nfin, nw;
    nfin = 0; nw = 0;
    @(posedge clk); #1;
    start16 = 1'b1; mode16 = 2'b00;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (finish16) nfin++;
      if (wen16) nw++;
      start16 = (k == 3) || finish16;
      @(posedge clk); #1;
    end
    tests++;
    if (nfin !== 1 || nw !== 16) begin
      fails++;
      $display("FAIL ignored_pulses: got fin=%0d wen=%0d want 1/16", nfin, nw);
    end
  endtask

  task automatic test_reset_mid();
    int nfin, k;
    @(posedge clk); #1;
    mode = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(wen && address == 8'h40) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    tests++;
    if (k >= 300) begin
      fails++;
      $display("FAIL reset_mid_reach: got timeout want addr 40");
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, finish, address, data, wen, memory_sel,
         verify_err, err_addr, err_count} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got busy=%b addr=%h wen=%b want 0",
               busy, address, wen);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nfin = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (finish || busy) nfin++;
    end
    tests++;
    if (nfin !== 0) begin
      fails++;
      $display("FAIL reset_mid_no_resume: got %0d active cycles want 0", nfin);
    end
    run_main(2'b00, 8'h00);
    tests++;
    if (nwen !== 256 || a_log[0] !== 8'h00 || fin_k !== 256) begin
      fails++;
      $display("FAIL reset_mid_restart: got nwen=%0d a0=%h fin=%0d",
               nwen, a_log[0], fin_k);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; mode = 2'b00; fill_value = 8'h00;
    start16 = 1'b0; mode16 = 2'b00; fill16 = 8'h00; q16 = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    test_reset();
    test_identity();
    test_constant();
    test_descending();
    test_descending16();
    test_verify();
    test_start_held();
    test_ignored_pulses();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
